// File: rtl/kgp_rf_pkg.sv
// Shared constants and clear-sequencer state encoding for the KGP-RISC register file.
package kgp_rf_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [0:0] seq_state_t;
  localparam seq_state_t SEQ_IDLE  = 1'b0;
  localparam seq_state_t SEQ_CLEAR = 1'b1;
endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks an index over every register, one per clock, to zero the file.
//   state     | meaning
//   SEQ_IDLE  | waiting for clr_req; file under normal read/write control
//   SEQ_CLEAR | zeroing regs[idx] each edge; leaves after idx NUM_REGS-1
module rf_clear_seq
  import kgp_rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      SEQ_IDLE: begin
        if (clr_req) begin
          state_d = SEQ_CLEAR;
          idx_d   = '0;
        end
      end
      SEQ_CLEAR: begin
        // index wraps to 0 naturally on the final edge
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy    = (state_q == SEQ_CLEAR);
  assign clr_we  = busy;
  assign clr_idx = idx_q;

endmodule

// File: rtl/register_file_2r1w.sv
// KGP-RISC architectural register file: two combinational read ports with write-through
// bypass, one synchronous write port, and a one-register-per-cycle hardware clear.
module register_file_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              busy
);
  import kgp_rf_pkg::*;

  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0]             regs_q [NUM_REGS];
  logic [DATA_W-1:0]             regs_d [NUM_REGS];
  logic                          clr_we;
  logic [kgp_rf_pkg::ADDR_W-1:0] clr_idx;
  logic                          wr_hit;

  rf_clear_seq u_clear_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // A port write is live only outside a clear and never to a hardwired-zero r0.
  assign wr_hit = wr_en && !busy && !(ZR && (wr_addr == '0));

  always_comb begin
    regs_d = regs_q;
    if (clr_we) begin
      regs_d[clr_idx] = '0;
    end else if (wr_hit) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    if (ZR && (rd_addr_a == '0)) begin
      rd_data_a = '0;
    end else if (wr_hit && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    if (ZR && (rd_addr_b == '0)) begin
      rd_data_b = '0;
    end else if (wr_hit && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed plus randomized bench for register_file_2r1w against an array-based reference model.
module tb_register_file_2r1w;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data;
  logic        wr_en, clr_req, busy;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_mem [32];
  int          m_clr_left;

  register_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wr_en && m_clr_left == 0 && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_clr_left = 0;
  endtask

  // Applies the rules for one rising edge using the inputs the DUT is about to sample.
  task automatic model_edge();
    if (m_clr_left > 0) begin
      m_mem[32 - m_clr_left] = 32'h0;
      m_clr_left--;
    end else begin
      if (wr_en && wr_addr != 5'd0) m_mem[wr_addr] = wr_data;
      if (clr_req) m_clr_left = 32;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    #1;
    check({tag, "_a"}, rd_data_a, exp_rd(rd_addr_a));
    check({tag, "_b"}, rd_data_b, exp_rd(rd_addr_b));
    check({tag, "_busy"}, {31'h0, busy}, {31'h0, m_clr_left > 0});
  endtask

  // Only used while idle with no write pending, so passing edges change nothing.
  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      check({tag, "_a"}, rd_data_a, exp_rd(rd_addr_a));
      check({tag, "_b"}, rd_data_b, exp_rd(rd_addr_b));
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0; clr_req = 1'b0;
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    idle_inputs();
    model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;

    // reset state
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check_all("rst_regs");
    @(negedge clk);
    rst_n = 1'b1;

    // basic write then read
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    #1;
    check("wr_r5_a", rd_data_a, 32'hDEADBEEF);
    check("wr_r5_b", rd_data_b, 32'hDEADBEEF);

    // write-through bypass before the edge
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    rd_addr_a = 5'd7; rd_addr_b = 5'd5;
    #1;
    check("bypass_a", rd_data_a, 32'h12345678);
    check("bypass_b_other", rd_data_b, 32'hDEADBEEF);
    tick();
    idle_inputs();
    check_ports("after_bypass");

    // zero register: write dropped, no bypass
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    #1;
    check("r0_nobypass_a", rd_data_a, 32'h0);
    check("r0_nobypass_b", rd_data_b, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("r0_after_a", rd_data_a, 32'h0);
    check("r0_after_b", rd_data_b, 32'h0);

    // fill r1..r31 with their index
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
      tick();
    end
    idle_inputs();
    check_all("filled");

    // clear sequence with a discarded write and an ignored clr_req mid-way
    @(posedge clk); #1;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      idle_inputs();
      rd_addr_a = 5'd3; rd_addr_b = 5'd30;
      if (cnt == 6) begin
        #1;
        check("mid_r3", rd_data_a, 32'h0);
        check("mid_r30", rd_data_b, 32'd30);
      end
      if (cnt == 8) begin
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h55AA55AA;
        rd_addr_a = 5'd10;
      end
      if (cnt == 12) clr_req = 1'b1;
      check_ports("clr_cycle");
      tick();
    end
    idle_inputs();
    check("busy_len", 32'(cnt), 32'd32);
    check("busy_done", {31'h0, busy}, 32'h0);
    rd_addr_a = 5'd10;
    #1;
    check("r10_discarded", rd_data_a, 32'h0);
    check_all("cleared");

    // first write after the clear is accepted
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFE0009;
    tick();
    idle_inputs();
    rd_addr_a = 5'd9;
    #1;
    check("post_clear_wr", rd_data_a, 32'hCAFE0009);

    // randomized traffic with occasional clears
    for (int k = 0; k < 400; k++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 5'($urandom);
      wr_data   = $urandom;
      clr_req   = ($urandom_range(0, 79) == 0);
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      rd_addr_b = 5'($urandom);
      check_ports("rand");
      tick();
    end
    idle_inputs();
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    check("rand_drain", {31'h0, busy}, {31'h0, m_clr_left > 0});
    check_all("rand_end");

    // simultaneous clr_req and write to r31
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hAA; clr_req = 1'b1;
    tick();
    idle_inputs();
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      rd_addr_a = 5'd31; rd_addr_b = 5'(cnt % 32);
      check_ports("simul");
      if (cnt == 32) check("simul_r31_last", rd_data_a, 32'hAA);
      tick();
    end
    check("simul_len", 32'(cnt), 32'd32);
    rd_addr_a = 5'd31;
    #1;
    check("simul_r31_zero", rd_data_a, 32'h0);

    // reset in the middle of a clear
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = $urandom | 32'h1;
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    rd_addr_a = 5'd20;
    #1;
    check("pre_rst_r20", rd_data_a, m_mem[20]);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_r20", rd_data_a, 32'h0);
    check_all("rst_mid_regs");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    check("restart_len", 32'(cnt), 32'd32);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_file_2r1w.md
# register_file_2r1w

Architectural register file for the single-cycle KGP-RISC datapath: 32 × 32-bit registers, two combinational read ports and one synchronous write port. The 5-bit write address is driven by the datapath's destination-register select mux. The block also contains a hardware clear sequencer that zeroes the whole file on request, one register per cycle, without a reset.

## Interface

Parameters:
- `DATA_W`, 32: register width.
- `ADDR_W`, 5: register address width; fixed to match the destination-select mux output.
- `ZERO_REG`, 1: when 1, register 0 always reads as 0 and writes to it are discarded.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rd_addr_a`  in  ADDR_W: read port A address.
- `rd_data_a`  out  DATA_W: read port A data (combinational).
- `rd_addr_b`  in  ADDR_W: read port B address.
- `rd_data_b`  out  DATA_W: read port B data (combinational).
- `wr_en`  in  1: write enable.
- `wr_addr`  in  ADDR_W: write address (output of the destination mux).
- `wr_data`  in  DATA_W: write data.
- `clr_req`  in  1: request a full-file clear (level, sampled on edge).
- `busy`  out  1: clear sequence in progress.

## Operation

- Reset (`rst_n`=0, asynchronous): all 32 registers go to 0; the sequencer goes to IDLE with index 0; `busy`=0. Read outputs are therefore 0.
- Write: on a rising edge with `wr_en`=1 and `busy`=0, `regs[wr_addr]` ← `wr_data`. A write to address 0 is dropped when `ZERO_REG`=1.
- Read: `rd_data_x` = `regs[rd_addr_x]`, with two overrides:
  - Address 0 returns 0 when `ZERO_REG`=1.
  - Write-through bypass: if `wr_en`=1, `busy`=0, `wr_addr`==`rd_addr_x` and the address is non-zero (or `ZERO_REG`=0), then `rd_data_x` = `wr_data` in the same cycle.
- Both read ports are independent and may address the same register.
- Clear sequencer states:
  - IDLE: on an edge with `clr_req`=1, go to CLEAR with idx=0.
  - CLEAR: each edge, `regs[idx]` ← 0 and idx increments. On the edge that clears idx 31, return to IDLE and wrap idx to 0.
- During CLEAR:
  - `wr_en` is ignored and the bypass is disabled.
  - `clr_req` is ignored; a new clear is not queued.
  - Reads return current contents, so already-cleared registers read 0 and the rest keep their old values.
- Simultaneous `clr_req` and `wr_en` in IDLE: the write commits on that edge, then the clear starts, so the written value is later zeroed.
- Reset asserted mid-clear: the sequence is aborted, all registers are zeroed immediately, the state is IDLE, and `busy` drops asynchronously.

## Timing

- Read latency: 0 cycles (combinational from address). The bypass path is combinational from `wr_en`, `wr_addr` and `wr_data`.
- Write latency: 1 edge; the value is visible through the storage array after the edge.
- `busy` is registered. It rises the cycle after the edge that samples `clr_req`, stays high for exactly 32 cycles, and falls on the edge that clears register 31.
- The first write accepted after a clear is on the edge at which `busy` is already 0.

## Structure

- Package `kgp_rf_pkg` holds:
  - `DATA_W`, `ADDR_W`, `NUM_REGS`=32 constants.
  - Sequencer state typedef (IDLE, CLEAR).
- Sub-module `rf_clear_seq` holds the FSM and 5-bit index counter. Its outputs are `busy`, `clr_we` and `clr_idx`.
- The top level holds the storage array, the write-port arbitration (clear wins while busy) and the read/bypass logic.

## Test plan

- **Reset values:** assert `rst_n`=0 → all reads return 0x0, `busy`=0. Release reset, write 0xDEADBEEF to r5 → r5 reads 0xDEADBEEF on the next cycle.
- **Bypass:** `wr_en`=1, `wr_addr`=7, `wr_data`=0x12345678, `rd_addr_a`=7 in the same cycle → `rd_data_a`=0x12345678 before the edge.
- **Zero register:** write 0xFFFFFFFF to r0 → both ports reading r0 return 0. The bypass is not applied to r0.
- **Clear sequence:**
  - Fill r1..r31 with index values, pulse `clr_req` one cycle → `busy` high for exactly 32 cycles.
  - Mid-sequence, r3 reads 0 while r30 still reads 30.
  - A write to r10 issued during the sequence is discarded (r10 reads 0 afterwards).
- **Simultaneous clear and write:** `clr_req`=1 and write 0xAA to r31 on the same edge → r31 reads 0xAA until the 32nd clear edge, then 0.
- **Reset mid-clear:** assert `rst_n` at clear cycle 10 → `busy`=0 immediately, all registers 0. A `clr_req` after release restarts a full 32-cycle clear.
